// File: rtl/btn_debounce_multi.sv
// N-channel push-button debouncer: 2-FF synchroniser, strict qualification window,
// debounced level plus one-cycle press, release and long-press pulses per channel.
module btn_debounce_multi #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEB_CYC    = 2000000,
  parameter int unsigned LONG_CYC   = 100000000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
  localparam int unsigned LONG_W = (LONG_CYC == 0) ? 1 : $clog2(LONG_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHK_ON  = 2'd1,
    PRESSED = 2'd2,
    CHK_OFF = 2'd3
  } state_e;

  logic [N_CH-1:0]   sync1_q, sync1_d;
  logic [N_CH-1:0]   sync2_q, sync2_d;
  logic [N_CH-1:0]   btn_s_c;
  state_e            state_q    [N_CH];
  state_e            state_d    [N_CH];
  logic [DEB_W-1:0]  deb_cnt_q  [N_CH];
  logic [DEB_W-1:0]  deb_cnt_d  [N_CH];
  logic [LONG_W-1:0] long_cnt_q [N_CH];
  logic [LONG_W-1:0] long_cnt_d [N_CH];
  logic [N_CH-1:0]   level_q, level_d;
  logic [N_CH-1:0]   press_q, press_d;
  logic [N_CH-1:0]   release_q, release_d;
  logic [N_CH-1:0]   long_q, long_d;

  // Next-state and output logic, one independent FSM per channel
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    btn_s_c = sync2_q ^ {N_CH{ACTIVE_LOW}};
    for (int ch = 0; ch < N_CH; ch++) begin
      state_d[ch]    = state_q[ch];
      deb_cnt_d[ch]  = deb_cnt_q[ch];
      long_cnt_d[ch] = long_cnt_q[ch];
      level_d[ch]    = level_q[ch];
      press_d[ch]    = 1'b0;
      release_d[ch]  = 1'b0;
      long_d[ch]     = 1'b0;
      case (state_q[ch])
        IDLE: begin
          long_cnt_d[ch] = '0;
          if (btn_s_c[ch]) begin
            state_d[ch]   = CHK_ON;
            deb_cnt_d[ch] = '0;
          end
        end
        CHK_ON: begin
          long_cnt_d[ch] = '0;
          if (!btn_s_c[ch]) begin
            state_d[ch] = IDLE;
          end else if (deb_cnt_q[ch] == DEB_LAST) begin
            state_d[ch] = PRESSED;
            level_d[ch] = 1'b1;
            press_d[ch] = 1'b1;
          end else begin
            deb_cnt_d[ch] = deb_cnt_q[ch] + DEB_W'(1);
          end
        end
        PRESSED: begin
          if (!btn_s_c[ch]) begin
            state_d[ch]   = CHK_OFF;
            deb_cnt_d[ch] = '0;
          end
          // Saturating hold timer; the final step fires the long-press pulse once
          if ((LONG_CYC != 0) && (long_cnt_q[ch] != LONG_MAX)) begin
            long_cnt_d[ch] = long_cnt_q[ch] + LONG_W'(1);
            long_d[ch]     = (long_cnt_q[ch] == LONG_LAST);
          end
        end
        CHK_OFF: begin
          if (btn_s_c[ch]) begin
            state_d[ch] = PRESSED;
          end else if (deb_cnt_q[ch] == DEB_LAST) begin
            state_d[ch]   = IDLE;
            level_d[ch]   = 1'b0;
            release_d[ch] = 1'b1;
          end else begin
            deb_cnt_d[ch] = deb_cnt_q[ch] + DEB_W'(1);
          end
        end
        default: state_d[ch] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch]    <= IDLE;
        deb_cnt_q[ch]  <= '0;
        long_cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int ch = 0; ch < N_CH; ch++) begin
        state_q[ch]    <= state_d[ch];
        deb_cnt_q[ch]  <= deb_cnt_d[ch];
        long_cnt_q[ch] <= long_cnt_d[ch];
      end
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: three instances (active-high, long-press disabled,
// active-low) checked against a stable-run-length reference model plus directed timing.
module tb_btn_debounce_multi;

  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_v [3];
  logic [3:0] lvl_o [3];
  logic [3:0] pp_o  [3];
  logic [3:0] rp_o  [3];
  logic [3:0] lp_o  [3];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  btn_debounce_multi #(.N_CH(4), .DEB_CYC(8), .LONG_CYC(32), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .btn(btn_v[0]), .level(lvl_o[0]),
    .press_pulse(pp_o[0]), .release_pulse(rp_o[0]), .long_pulse(lp_o[0]));
  btn_debounce_multi #(.N_CH(4), .DEB_CYC(8), .LONG_CYC(0), .ACTIVE_LOW(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .btn(btn_v[1]), .level(lvl_o[1]),
    .press_pulse(pp_o[1]), .release_pulse(rp_o[1]), .long_pulse(lp_o[1]));
  btn_debounce_multi #(.N_CH(4), .DEB_CYC(8), .LONG_CYC(32), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .btn(btn_v[2]), .level(lvl_o[2]),
    .press_pulse(pp_o[2]), .release_pulse(rp_o[2]), .long_pulse(lp_o[2]));

  // Model: level toggles once the synchronised input has disagreed with it for
  // DEB+1 consecutive samples; hold time counts cycles pressed with no disagreement.
  typedef struct {
    logic sh1;
    logic sh2;
    logic level;
    int   run;
    int   hold;
    logic pp;
    logic rp;
    logic lp;
  } mdl_t;

  mdl_t m [3][4];

  function automatic mdl_t mzero();
    mdl_t z;
    z.sh1 = 1'b0; z.sh2 = 1'b0; z.level = 1'b0; z.run = 0; z.hold = 0;
    z.pp = 1'b0; z.rp = 1'b0; z.lp = 1'b0;
    return z;
  endfunction

  function automatic mdl_t mstep(mdl_t cur, logic raw, logic al, int lc);
    mdl_t n;
    logic s;
    n = cur;
    s = cur.sh2 ^ al;
    n.sh1 = raw;
    n.sh2 = cur.sh1;
    n.pp = 1'b0; n.rp = 1'b0; n.lp = 1'b0;
    if (!cur.level) n.hold = 0;
    else if (cur.run == 0 && cur.hold < lc) begin
      n.hold = cur.hold + 1;
      n.lp   = (n.hold == lc);
    end
    if (s != cur.level) begin
      n.run = cur.run + 1;
      if (n.run == DEB + 1) begin
        n.level = ~cur.level;
        n.pp    = ~cur.level;
        n.rp    = cur.level;
        n.run   = 0;
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < 4; c++) m[d][c] = mzero();
    end else begin
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < 4; c++)
          m[d][c] = mstep(m[d][c], btn_v[d][c], (d == 2), (d == 1) ? 0 : 32);
    end
  end

  logic [15:0] got [3];
  logic [15:0] expv [3];
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      got[d]  = {lvl_o[d], pp_o[d], rp_o[d], lp_o[d]};
      expv[d] = '0;
      for (int c = 0; c < 4; c++) begin
        expv[d][12+c] = m[d][c].level;
        expv[d][8+c]  = m[d][c].pp;
        expv[d][4+c]  = m[d][c].rp;
        expv[d][c]    = m[d][c].lp;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    btn_v[0] = 4'h0; btn_v[1] = 4'h0; btn_v[2] = 4'hF;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (got[d] !== 16'h0) begin
        fails++; $display("FAIL reset_state dut%0d: got %h, want 0000", d, got[d]);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (got[d] !== 16'h0) begin
          fails++; $display("FAIL reset_release dut%0d cyc%0d: got %h, want 0000", d, i, got[d]);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    btn_v[0][0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (got[0] !== expv[0]) begin
        fails++; $display("FAIL press_model cyc%0d: got %h, want %h", i, got[0], expv[0]);
      end
      checks++;
      if (pp_o[0] !== ((i == 11) ? 4'b0001 : 4'b0000) || lvl_o[0] !== ((i >= 11) ? 4'b0001 : 4'b0000)) begin
        fails++; $display("FAIL press_timing cyc%0d: pp %b lvl %b", i, pp_o[0], lvl_o[0]);
      end
    end
    btn_v[0][0] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (rp_o[0] !== ((i == 11) ? 4'b0001 : 4'b0000) || got[0] !== expv[0]) begin
        fails++; $display("FAIL release_timing cyc%0d: got %h, want %h", i, got[0], expv[0]);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      btn_v[0][1] = ((i / 3) % 2 == 0);
      @(negedge clk);
      checks++;
      if (lvl_o[0][1] !== 1'b0 || pp_o[0][1] !== 1'b0 || rp_o[0][1] !== 1'b0 || got[0] !== expv[0]) begin
        fails++; $display("FAIL bounce cyc%0d: got %h, want %h", i, got[0], expv[0]);
      end
    end
    btn_v[0][1] = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (got[0] !== 16'h0) begin
      fails++; $display("FAIL bounce_settle: got %h, want 0000", got[0]);
    end
  endtask

  task automatic test_release_bounce();
    int pp_seen;
    pp_seen = 0;
    btn_v[0][2] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (pp_o[0][2]) pp_seen++;
    end
    for (int i = 1; i <= 14; i++) begin
      btn_v[0][2] = (i > 4);
      @(negedge clk);
      if (pp_o[0][2]) pp_seen++;
      checks++;
      if (lvl_o[0][2] !== 1'b1 || rp_o[0][2] !== 1'b0 || got[0] !== expv[0]) begin
        fails++; $display("FAIL rel_bounce cyc%0d: got %h, want %h", i, got[0], expv[0]);
      end
    end
    checks++;
    if (pp_seen != 1) begin
      fails++; $display("FAIL rel_bounce_presses: got %0d press pulses, want 1", pp_seen);
    end
    btn_v[0][2] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (rp_o[0][2] !== (i == 11) || lvl_o[0][2] !== (i < 11) || pp_o[0][2] !== 1'b0) begin
        fails++; $display("FAIL rel_final cyc%0d: rp %b lvl %b pp %b", i, rp_o[0][2], lvl_o[0][2], pp_o[0][2]);
      end
    end
  endtask

  task automatic test_long_press();
    btn_v[0][3] = 1'b1;
    btn_v[1][3] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      checks++;
      if (pp_o[0][3] !== (i == 11) || lp_o[0][3] !== (i == 43)) begin
        fails++; $display("FAIL long_a cyc%0d: pp %b lp %b", i, pp_o[0][3], lp_o[0][3]);
      end
      checks++;
      if (pp_o[1][3] !== (i == 11) || lp_o[1] !== 4'b0000) begin
        fails++; $display("FAIL long_off cyc%0d: pp %b lp %b", i, pp_o[1][3], lp_o[1]);
      end
    end
    btn_v[0][3] = 1'b0;
    btn_v[1][3] = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rp_o[d][3] !== (i == 11) || lp_o[d][3] !== 1'b0 || got[d] !== expv[d]) begin
          fails++; $display("FAIL long_release dut%0d cyc%0d: got %h, want %h", d, i, got[d], expv[d]);
        end
      end
    end
  endtask

  task automatic test_polarity();
    btn_v[2] = 4'b1010;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (pp_o[2] !== ((i == 11) ? 4'b0101 : 4'b0000) || got[2] !== expv[2]) begin
        fails++; $display("FAIL polarity_press cyc%0d: pp %b got %h want %h", i, pp_o[2], got[2], expv[2]);
      end
    end
    btn_v[2] = 4'b1111;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (rp_o[2] !== ((i == 11) ? 4'b0101 : 4'b0000) || got[2] !== expv[2]) begin
        fails++; $display("FAIL polarity_release cyc%0d: rp %b got %h want %h", i, rp_o[2], got[2], expv[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    btn_v[0][1] = 1'b1;
    repeat (14) @(negedge clk);
    btn_v[0][0] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (lvl_o[0] !== 4'b0010) begin
      fails++; $display("FAIL mid_setup: lvl %b, want 0010", lvl_o[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (got[d] !== 16'h0) begin
        fails++; $display("FAIL mid_reset dut%0d: got %h, want 0000", d, got[d]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checks++;
      if (pp_o[0][1] !== (i == 11) || rp_o[0] !== 4'b0000 || got[0] !== expv[0]) begin
        fails++; $display("FAIL requalify cyc%0d: got %h, want %h", i, got[0], expv[0]);
      end
    end
    btn_v[0] = 4'h0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_random();
    int rate;
    for (int i = 0; i < 2000; i++) begin
      rate = (i < 1000) ? 8 : 50;
      for (int d = 0; d < 3; d++)
        for (int c = 0; c < 4; c++)
          if ($urandom_range(rate - 1, 0) == 0) btn_v[d][c] = ~btn_v[d][c];
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (got[d] !== expv[d]) begin
          fails++; $display("FAIL random dut%0d cyc%0d: got %h, want %h", d, i, got[d], expv[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_long_press();
    test_polarity();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
